commit_unit: RTL and testbench
==============================

# commit_unit

Parametrised in-order commit stage for the Tomasulo core; it succeeds the single-entry write-results control. Each cycle it inspects the oldest `commit_width` ROB entries and retires the leading run of ready non-memory entries into the regfile. A two-state memory FSM launches loads/stores (word and byte) at the ROB head and holds registered requests to L1 until `dmem_resp`.

## Interface
- `data_width`, 16: value/regfile width (≥16).
- `tag_width`, 3: ROB tag width.
- `commit_width`, 2: ROB head entries examined and regfile write ports (1..4).
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `valid_in` in [commit_width]: entry i is ready; entry 0 is the ROB head.
- `opcode_in` in lc3b_opcode[commit_width]: entry opcodes.
- `dest_in` in lc3b_reg[commit_width]: destination registers.
- `tag_in` in [commit_width][tag_width]: ROB tags.
- `value_in` in [commit_width][data_width]: result, or store data for stores.
- `addr_in` in lc3b_word[commit_width]: effective address (memory ops).
- `dmem_resp` in 1: L1 done.
- `dmem_rdata` in lc3b_word: L1 read data.
- `dmem_read`, `dmem_write` out 1: registered L1 strobes.
- `dmem_address` out lc3b_word: registered address.
- `dmem_wdata` out lc3b_word: registered store data.
- `dmem_byte_enable` out 2: registered byte enables.
- `dest_a` out lc3b_reg[commit_width]: write-port register.
- `tag_out` out [commit_width][tag_width]: committing tag; the regfile clears busy only on a tag match.
- `value_out` out [commit_width][data_width]: write data.
- `ld_regfile_value`, `ld_regfile_busy` out [commit_width]: per-port enables.
- `re_count` out $clog2(commit_width+1): entries popped this cycle.

## Operation
- Commit group: k = length of the leading run of `valid_in[i]` whose opcodes are non-memory (not ldr/ldb/str/stb) and not `op_br`-family with a nonzero `dest_in`. Port i = entry i for i<k; `re_count`=k.
- Control-flow entries with no destination (br, jmp, str-type) pop without asserting load enables; they still count in `re_count`.
- Same-dest collision in a group: the younger entry wins. The older port's `ld_regfile_value` is deasserted. Its `ld_regfile_busy` is still asserted, with its own tag.
- Memory entry at index >0: entries before it commit and the group stops. Memory entry at index 0, FSM in IDLE: group is empty, the request is launched, and FSM goes to MEM_WAIT.
- FSM states:
  - IDLE: on a head memory op, latch strobes, address, wdata and byte enables, then go to MEM_WAIT.
  - MEM_WAIT: hold all dmem outputs constant and commit nothing. On `dmem_resp`, retire the head: `re_count`=1. For loads, port 0 loads `dmem_rdata` (processed) and asserts both enables. For stores, neither enable is asserted. Strobes drop next cycle and FSM returns to IDLE.
- Byte ops: ldb selects byte `addr_in[0]` (1 = high) and sign-extends it to data_width. stb drives the byte in both lanes of wdata, with byte_enable = 01 for an even address and 10 for an odd one. Word ops use byte_enable 11 and an address with bit0 cleared.
- ldr/ldb results are `dmem_rdata` extended to data_width. ALU values pass through unchanged.
- `dmem_resp` in IDLE is ignored.

## Timing
- Non-memory commit is combinational. A ready head retires in the cycle it is presented; the ROB pops on the next edge.
- Memory: head op seen at cycle N; strobes and address valid from N+1. With `dmem_resp` at cycle M ≥ N+1, regfile write and pop happen at M, strobes are low at M+1, and the next group can commit at M+1.
- Reset values: FSM IDLE; dmem_read/write 0; dmem_address/wdata 0; byte_enable 00. All combinational outputs evaluate to 0 while `valid_in`=0.
- `rst` mid-MEM_WAIT aborts the request; strobes are 0 next cycle, with no pop and no write.

## Configuration
- `COMMIT_PERF_EN` defined: adds outputs `perf_commits` (32, entries retired, summing `re_count`) and `perf_mem_stall` (32, cycles in MEM_WAIT without resp). Both reset to 0 and wrap at 2^32.
- Undefined: these ports and their counters are absent, and behaviour is otherwise identical.

## Structure
- Package `lc3b_types` holds lc3b_opcode, lc3b_reg and lc3b_word. Add `commit_state_t` (IDLE, MEM_WAIT) and `is_mem_op()`/`is_byte_op()` functions to it.
- One sub-module, `commit_mem_fsm`: request latch, FSM, byte steering and load extension. The top level holds group selection and collision masking.

## Test plan
- Two ALU entries (R1=0x0005, R2=0x1234) valid → both ports write in the same cycle, `re_count`=2.
- Two entries, both with dest R3 (0x0001 tag 1, 0x0002 tag 2) → only port 1 `ld_regfile_value`, R3=0x0002; both ports assert busy.
- ALU entry, then ldr at index 1 → `re_count`=1. Next cycle the ldr is at the head, and strobes rise one cycle later.
- ldb at addr 0x3001, rdata 0x80FF, resp 3 cycles later → held outputs throughout, value_out 0xFF80, `re_count`=1 at resp only.
- stb at 0x2000, data 0x00AB → wdata 0xABAB, byte_enable 01, no regfile enables at resp.
- `rst` during MEM_WAIT, then `dmem_resp` → strobes 0, no pop; with `COMMIT_PERF_EN` defined, the counters read 0.

Source files
------------

// File: rtl/commit_unit_pkg.sv
// LC-3b type definitions shared by the commit stage: opcodes, register and word
// types, the memory FSM state and opcode classification helpers.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [2:0]  lc3b_reg;

    typedef enum logic [3:0] {
        op_br   = 4'b0000, op_add  = 4'b0001, op_ldb  = 4'b0010, op_stb  = 4'b0011,
        op_jsr  = 4'b0100, op_and  = 4'b0101, op_ldr  = 4'b0110, op_str  = 4'b0111,
        op_rti  = 4'b1000, op_not  = 4'b1001, op_ldi  = 4'b1010, op_sti  = 4'b1011,
        op_jmp  = 4'b1100, op_shf  = 4'b1101, op_lea  = 4'b1110, op_trap = 4'b1111
    } lc3b_opcode;

    typedef enum logic {IDLE, MEM_WAIT} commit_state_t;

    function automatic logic is_mem_op(lc3b_opcode op);
        return op inside {op_ldr, op_ldb, op_str, op_stb};
    endfunction

    function automatic logic is_byte_op(lc3b_opcode op);
        return op inside {op_ldb, op_stb};
    endfunction

    function automatic logic is_load_op(lc3b_opcode op);
        return op inside {op_ldr, op_ldb};
    endfunction

    function automatic logic is_branch_op(lc3b_opcode op);
        return op inside {op_br, op_jmp};
    endfunction

    // Entries that retire without touching the regfile.
    function automatic logic has_dest(lc3b_opcode op);
        return !(op inside {op_br, op_jmp, op_str, op_stb, op_sti, op_rti});
    endfunction

endpackage

// File: rtl/commit_mem_fsm.sv
// Head-of-ROB memory sequencer: latches the L1 request, waits for dmem_resp,
// steers byte lanes for stores and extends load data to data_width.
module commit_mem_fsm
    import lc3b_types::*;
#(
    parameter int data_width = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  head_valid,
    input  lc3b_opcode            head_opcode,
    input  logic [data_width-1:0] head_value,
    input  lc3b_word              head_addr,
    input  logic                  dmem_resp,
    input  lc3b_word              dmem_rdata,
    output logic                  dmem_read,
    output logic                  dmem_write,
    output lc3b_word              dmem_address,
    output lc3b_word              dmem_wdata,
    output logic [1:0]            dmem_byte_enable,
    output logic                  mem_busy,
    output logic                  mem_retire,
    output logic                  retire_load,
    output logic [data_width-1:0] load_value
);

    commit_state_t state, next_state;
    logic          launch;
    logic          lat_byte;
    logic          lat_odd;
    logic [7:0]    rbyte;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        launch     = 1'b0;
        next_state = state;
        case (state)
            IDLE: begin
                if (head_valid && is_mem_op(head_opcode)) begin
                    launch     = 1'b1;
                    next_state = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (dmem_resp) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        mem_busy    = (state == MEM_WAIT);
        mem_retire  = mem_busy && dmem_resp && !rst;
        retire_load = mem_retire && dmem_read;
        rbyte       = lat_odd ? dmem_rdata[15:8] : dmem_rdata[7:0];
        load_value  = lat_byte ? data_width'($signed(rbyte)) : data_width'($signed(dmem_rdata));
    end

    // Request stays frozen from launch until the response retires it.
    always_ff @(posedge clk) begin
        if (rst) begin
            dmem_read        <= 1'b0;
            dmem_write       <= 1'b0;
            dmem_address     <= '0;
            dmem_wdata       <= '0;
            dmem_byte_enable <= '0;
            lat_byte         <= 1'b0;
            lat_odd          <= 1'b0;
        end else if (launch) begin
            dmem_read  <= is_load_op(head_opcode);
            dmem_write <= !is_load_op(head_opcode);
            lat_byte   <= is_byte_op(head_opcode);
            lat_odd    <= head_addr[0];
            if (is_byte_op(head_opcode)) begin
                dmem_address     <= head_addr;
                dmem_byte_enable <= head_addr[0] ? 2'b10 : 2'b01;
            end else begin
                dmem_address     <= {head_addr[15:1], 1'b0};
                dmem_byte_enable <= '1;
            end
            if (is_load_op(head_opcode))
                dmem_wdata <= '0;
            else if (is_byte_op(head_opcode))
                dmem_wdata <= {2{head_value[7:0]}};
            else
                dmem_wdata <= head_value[15:0];
        end else if (mem_retire) begin
            dmem_read  <= 1'b0;
            dmem_write <= 1'b0;
        end
    end

endmodule

// File: rtl/commit_unit.sv
// In-order multi-entry commit stage: retires the leading ready run of the ROB
// head into the regfile and hands head memory ops to commit_mem_fsm.
// Optional COMMIT_PERF_EN adds perf_commits / perf_mem_stall counters.
module commit_unit
    import lc3b_types::*;
#(
    parameter int data_width   = 16,
    parameter int tag_width    = 3,
    parameter int commit_width = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [commit_width-1:0]              valid_in,
    input  lc3b_opcode                           opcode_in [commit_width],
    input  lc3b_reg                              dest_in   [commit_width],
    input  logic [tag_width-1:0]                 tag_in    [commit_width],
    input  logic [data_width-1:0]                value_in  [commit_width],
    input  lc3b_word                             addr_in   [commit_width],
    input  logic                                 dmem_resp,
    input  lc3b_word                             dmem_rdata,
    output logic                                 dmem_read,
    output logic                                 dmem_write,
    output lc3b_word                             dmem_address,
    output lc3b_word                             dmem_wdata,
    output logic [1:0]                           dmem_byte_enable,
    output lc3b_reg                              dest_a    [commit_width],
    output logic [tag_width-1:0]                 tag_out   [commit_width],
    output logic [data_width-1:0]                value_out [commit_width],
    output logic [commit_width-1:0]              ld_regfile_value,
    output logic [commit_width-1:0]              ld_regfile_busy,
    output logic [$clog2(commit_width+1)-1:0]    re_count
`ifdef COMMIT_PERF_EN
    ,
    output logic [31:0]                          perf_commits,
    output logic [31:0]                          perf_mem_stall
`endif
);

    localparam int cnt_w = $clog2(commit_width + 1);

    logic [commit_width-1:0] in_grp;
    logic [commit_width-1:0] wr;
    logic [cnt_w-1:0]        grp_count;
    logic                    stop;
    logic                    mem_busy;
    logic                    mem_retire;
    logic                    retire_load;
    logic [data_width-1:0]   load_value;

    commit_mem_fsm #(.data_width(data_width)) u_mem_fsm (
        .clk              (clk),
        .rst              (rst),
        .head_valid       (valid_in[0]),
        .head_opcode      (opcode_in[0]),
        .head_value       (value_in[0]),
        .head_addr        (addr_in[0]),
        .dmem_resp        (dmem_resp),
        .dmem_rdata       (dmem_rdata),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_address     (dmem_address),
        .dmem_wdata       (dmem_wdata),
        .dmem_byte_enable (dmem_byte_enable),
        .mem_busy         (mem_busy),
        .mem_retire       (mem_retire),
        .retire_load      (retire_load),
        .load_value       (load_value)
    );

    always_comb begin
        in_grp    = '0;
        wr        = '0;
        grp_count = '0;
        stop      = mem_busy;
        for (int unsigned i = 0; i < commit_width; i++) begin
            if (!stop && valid_in[i] && !is_mem_op(opcode_in[i]) &&
                !(is_branch_op(opcode_in[i]) && dest_in[i] != '0)) begin
                in_grp[i] = 1'b1;
                wr[i]     = has_dest(opcode_in[i]);
                grp_count = grp_count + cnt_w'(1);
            end else begin
                stop = 1'b1;
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < commit_width; i++) begin
            dest_a[i]    = '0;
            tag_out[i]   = '0;
            value_out[i] = '0;
        end
        ld_regfile_value = '0;
        ld_regfile_busy  = '0;
        re_count         = grp_count;
        if (mem_retire) begin
            re_count   = cnt_w'(1);
            dest_a[0]  = dest_in[0];
            tag_out[0] = tag_in[0];
            if (retire_load) begin
                value_out[0]        = load_value;
                ld_regfile_value[0] = 1'b1;
                ld_regfile_busy[0]  = 1'b1;
            end
        end else begin
            for (int unsigned i = 0; i < commit_width; i++) begin
                if (in_grp[i]) begin
                    dest_a[i]    = dest_in[i];
                    tag_out[i]   = tag_in[i];
                    value_out[i] = value_in[i];
                end
                ld_regfile_busy[i]  = wr[i];
                ld_regfile_value[i] = wr[i];
                // A younger writer of the same register masks the value write but
                // the older tag still clears busy if it is the current owner.
                for (int unsigned j = i + 1; j < commit_width; j++) begin
                    if (wr[j] && dest_in[j] == dest_in[i]) ld_regfile_value[i] = 1'b0;
                end
            end
        end
    end

`ifdef COMMIT_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_commits   <= '0;
            perf_mem_stall <= '0;
        end else begin
            perf_commits <= perf_commits + 32'(re_count);
            if (mem_busy && !dmem_resp) perf_mem_stall <= perf_mem_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_commit_unit.sv
// Self-checking bench for commit_unit: directed scenarios with literal
// expectations, then randomized ROB traffic against a queue-based model.
module tb_commit_unit;
    import lc3b_types::*;

    localparam int DW = 16;
    localparam int TW = 3;
    localparam int CW = 2;
    localparam int RW = $clog2(CW + 1);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [CW-1:0]   valid_in;
    lc3b_opcode      opcode_in [CW];
    lc3b_reg         dest_in   [CW];
    logic [TW-1:0]   tag_in    [CW];
    logic [DW-1:0]   value_in  [CW];
    lc3b_word        addr_in   [CW];
    logic            dmem_resp = 1'b0;
    lc3b_word        dmem_rdata = '0;
    logic            dmem_read, dmem_write;
    lc3b_word        dmem_address, dmem_wdata;
    logic [1:0]      dmem_byte_enable;
    lc3b_reg         dest_a    [CW];
    logic [TW-1:0]   tag_out   [CW];
    logic [DW-1:0]   value_out [CW];
    logic [CW-1:0]   ld_regfile_value, ld_regfile_busy;
    logic [RW-1:0]   re_count;
`ifdef COMMIT_PERF_EN
    logic [31:0]     perf_commits, perf_mem_stall;
`endif

    always #5 clk = ~clk;

    commit_unit #(.data_width(DW), .tag_width(TW), .commit_width(CW)) dut (
        .clk              (clk),
        .rst              (rst),
        .valid_in         (valid_in),
        .opcode_in        (opcode_in),
        .dest_in          (dest_in),
        .tag_in           (tag_in),
        .value_in         (value_in),
        .addr_in          (addr_in),
        .dmem_resp        (dmem_resp),
        .dmem_rdata       (dmem_rdata),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_address     (dmem_address),
        .dmem_wdata       (dmem_wdata),
        .dmem_byte_enable (dmem_byte_enable),
        .dest_a           (dest_a),
        .tag_out          (tag_out),
        .value_out        (value_out),
        .ld_regfile_value (ld_regfile_value),
        .ld_regfile_busy  (ld_regfile_busy),
        .re_count         (re_count)
`ifdef COMMIT_PERF_EN
        ,
        .perf_commits     (perf_commits),
        .perf_mem_stall   (perf_mem_stall)
`endif
    );

    typedef struct {
        lc3b_opcode    op;
        lc3b_reg       dest;
        logic [TW-1:0] tag;
        logic [DW-1:0] val;
        lc3b_word      addr;
        bit            rdy;
    } entry_t;

    entry_t        q[$];
    int            n_checks = 0;
    int            n_errors = 0;
    bit            run = 0;
    logic [TW-1:0] tag_ctr = '0;

    // Outstanding request as the spec describes it.
    bit            pending = 0;
    bit            p_load, p_byte;
    lc3b_word      p_addr, p_wdata;
    logic [1:0]    p_be;
    logic [31:0]   m_commits = 0, m_stall = 0;

    int            e_re, k;
    bit            e_launch, e_retire;
    logic [CW-1:0] e_ldv, e_ldb;
    lc3b_reg       e_dest  [CW];
    logic [TW-1:0] e_tag   [CW];
    logic [DW-1:0] e_value [CW];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_mem(lc3b_opcode op);
        return op == op_ldr || op == op_ldb || op == op_str || op == op_stb;
    endfunction
    function automatic bit m_load(lc3b_opcode op);
        return op == op_ldr || op == op_ldb;
    endfunction
    function automatic bit m_byte(lc3b_opcode op);
        return op == op_ldb || op == op_stb;
    endfunction
    function automatic bit m_branch(lc3b_opcode op);
        return op == op_br || op == op_jmp;
    endfunction
    function automatic bit m_writes(lc3b_opcode op);
        return !(op == op_br || op == op_jmp || op == op_str || op == op_stb ||
                 op == op_sti || op == op_rti);
    endfunction
    function automatic logic [DW-1:0] sext8(logic [7:0] b);
        return {{(DW-8){b[7]}}, b};
    endfunction

    function automatic entry_t mk(lc3b_opcode op, int dest, int tag, int val, int addr);
        entry_t e;
        e.op = op; e.dest = lc3b_reg'(dest); e.tag = TW'(tag);
        e.val = DW'(val); e.addr = 16'(addr); e.rdy = 1;
        return e;
    endfunction

    function automatic entry_t rand_entry();
        entry_t e;
        int r;
        r = int'($urandom % 20);
        if (r < 9) begin
            case ($urandom % 5)
                0: e.op = op_add;
                1: e.op = op_and;
                2: e.op = op_not;
                3: e.op = op_shf;
                default: e.op = op_lea;
            endcase
        end else if (r < 12) e.op = ($urandom % 2 == 0) ? op_br : op_jmp;
        else if (r < 14) e.op = op_ldr;
        else if (r < 16) e.op = op_ldb;
        else if (r < 18) e.op = op_str;
        else             e.op = op_stb;
        e.dest = lc3b_reg'($urandom);
        if (m_branch(e.op) && ($urandom % 4 != 0)) e.dest = '0;
        e.tag   = tag_ctr;
        tag_ctr = tag_ctr + 1'b1;
        e.val   = DW'($urandom);
        e.addr  = 16'($urandom);
        e.rdy   = 1;
        return e;
    endfunction

    task automatic drive();
        for (int i = 0; i < CW; i++) begin
            if (i < q.size()) begin
                valid_in[i]  = q[i].rdy;
                opcode_in[i] = q[i].op;
                dest_in[i]   = q[i].dest;
                tag_in[i]    = q[i].tag;
                value_in[i]  = q[i].val;
                addr_in[i]   = q[i].addr;
            end else begin
                valid_in[i]  = 1'b0;
                opcode_in[i] = op_add;
                dest_in[i]   = '0;
                tag_in[i]    = '0;
                value_in[i]  = '0;
                addr_in[i]   = '0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        drive();
        @(negedge clk);
        #1;
    endtask

    // Compare process: expected outputs derived from the queue and request state.
    always @(negedge clk) begin
        if (run && !rst) begin
            e_ldv = '0; e_ldb = '0; e_re = 0; e_launch = 0; e_retire = 0;
            for (int i = 0; i < CW; i++) begin
                e_dest[i] = '0; e_tag[i] = '0; e_value[i] = '0;
            end
            if (pending) begin
                if (dmem_resp) begin
                    e_retire = 1;
                    e_re     = 1;
                    if (p_load) begin
                        e_ldv[0]   = 1'b1;
                        e_ldb[0]   = 1'b1;
                        e_dest[0]  = q[0].dest;
                        e_tag[0]   = q[0].tag;
                        e_value[0] = p_byte ? sext8(p_addr[0] ? dmem_rdata[15:8] : dmem_rdata[7:0])
                                            : dmem_rdata;
                    end
                end
            end else begin
                k = 0;
                while (k < CW && k < q.size() && q[k].rdy && !m_mem(q[k].op) &&
                       !(m_branch(q[k].op) && q[k].dest != 0))
                    k++;
                e_re = k;
                e_launch = (k == 0) && (q.size() > 0) && q[0].rdy && m_mem(q[0].op);
                for (int i = 0; i < k; i++) begin
                    if (m_writes(q[i].op)) begin
                        e_ldb[i] = 1'b1;
                        e_ldv[i] = 1'b1;
                        for (int j = i + 1; j < k; j++)
                            if (m_writes(q[j].op) && q[j].dest == q[i].dest) e_ldv[i] = 1'b0;
                        e_dest[i]  = q[i].dest;
                        e_tag[i]   = q[i].tag;
                        e_value[i] = q[i].val;
                    end
                end
            end
            check("re_count", 32'(re_count), e_re);
            check("ld_regfile_value", 32'(ld_regfile_value), 32'(e_ldv));
            check("ld_regfile_busy", 32'(ld_regfile_busy), 32'(e_ldb));
            for (int i = 0; i < CW; i++) begin
                if (e_ldb[i]) begin
                    check($sformatf("dest_a[%0d]", i), 32'(dest_a[i]), 32'(e_dest[i]));
                    check($sformatf("tag_out[%0d]", i), 32'(tag_out[i]), 32'(e_tag[i]));
                    check($sformatf("value_out[%0d]", i), 32'(value_out[i]), 32'(e_value[i]));
                end
            end
            check("dmem_read", 32'(dmem_read), 32'(pending && p_load));
            check("dmem_write", 32'(dmem_write), 32'(pending && !p_load));
            if (pending) begin
                check("dmem_address", 32'(dmem_address), 32'(p_addr));
                check("dmem_byte_enable", 32'(dmem_byte_enable), 32'(p_be));
                if (!p_load) check("dmem_wdata", 32'(dmem_wdata), 32'(p_wdata));
            end
`ifdef COMMIT_PERF_EN
            check("perf_commits", perf_commits, m_commits);
            check("perf_mem_stall", perf_mem_stall, m_stall);
`endif
        end
    end

    // Model advance: pop retired entries and open/close the outstanding request.
    always @(posedge clk) begin
        if (rst) begin
            pending   = 0;
            m_commits = 0;
            m_stall   = 0;
        end else if (run) begin
            if (pending) begin
                if (e_retire) begin
                    pending = 0;
                    void'(q.pop_front());
                    m_commits = m_commits + 1;
                end else begin
                    m_stall = m_stall + 1;
                end
            end else begin
                for (int i = 0; i < e_re; i++) void'(q.pop_front());
                m_commits = m_commits + 32'(e_re);
                if (e_launch) begin
                    pending = 1;
                    p_load  = m_load(q[0].op);
                    p_byte  = m_byte(q[0].op);
                    p_addr  = p_byte ? q[0].addr : (q[0].addr & 16'hFFFE);
                    p_be    = p_byte ? (q[0].addr[0] ? 2'b10 : 2'b01) : 2'b11;
                    p_wdata = p_byte ? {q[0].val[7:0], q[0].val[7:0]} : q[0].val;
                end
            end
        end
    end

    initial begin
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_dmem_read", 32'(dmem_read), 0);
        check("rst_dmem_write", 32'(dmem_write), 0);
        check("rst_dmem_address", 32'(dmem_address), 0);
        check("rst_dmem_wdata", 32'(dmem_wdata), 0);
        check("rst_byte_enable", 32'(dmem_byte_enable), 0);
        check("rst_re_count", 32'(re_count), 0);
        check("idle_value_out0", 32'(value_out[0]), 0);
        check("idle_dest_a1", 32'(dest_a[1]), 0);
        tick();
        rst = 1'b0;
        run = 1;

        // Two independent ALU results.
        q.push_back(mk(op_add, 1, 0, 16'h0005, 0));
        q.push_back(mk(op_add, 2, 1, 16'h1234, 0));
        settle();
        check("t1_re_count", 32'(re_count), 2);
        check("t1_ld_value", 32'(ld_regfile_value), 32'b11);
        check("t1_value0", 32'(value_out[0]), 32'h0005);
        check("t1_value1", 32'(value_out[1]), 32'h1234);
        check("t1_dest1", 32'(dest_a[1]), 2);

        // Same destination twice: younger wins, both clear busy.
        tick();
        q.push_back(mk(op_add, 3, 1, 16'h0001, 0));
        q.push_back(mk(op_and, 3, 2, 16'h0002, 0));
        settle();
        check("t2_ld_value", 32'(ld_regfile_value), 32'b10);
        check("t2_ld_busy", 32'(ld_regfile_busy), 32'b11);
        check("t2_value1", 32'(value_out[1]), 32'h0002);
        check("t2_tag0", 32'(tag_out[0]), 1);

        // ALU followed by ldr: group stops at the load.
        tick();
        q.push_back(mk(op_add, 4, 2, 16'h0042, 0));
        q.push_back(mk(op_ldr, 5, 3, 0, 16'h4003));
        settle();
        check("t3_re_first", 32'(re_count), 1);
        tick();
        settle();
        check("t3_re_launch", 32'(re_count), 0);
        check("t3_read_launch", 32'(dmem_read), 0);
        tick();
        dmem_resp = 1'b1; dmem_rdata = 16'h1357;
        settle();
        check("t3_read_up", 32'(dmem_read), 1);
        check("t3_address", 32'(dmem_address), 32'h4002);
        check("t3_re_resp", 32'(re_count), 1);
        check("t3_value", 32'(value_out[0]), 32'h1357);
        tick();
        dmem_resp = 1'b0;
        settle();
        check("t3_read_down", 32'(dmem_read), 0);

        // ldb from odd address, response after three wait cycles.
        tick();
        q.push_back(mk(op_ldb, 6, 4, 0, 16'h3001));
        settle();
        for (int c = 1; c <= 3; c++) begin
            tick();
            dmem_resp = (c == 3); dmem_rdata = 16'h80FF;
            settle();
            check("t4_read_held", 32'(dmem_read), 1);
            check("t4_addr_held", 32'(dmem_address), 32'h3001);
            check("t4_re", 32'(re_count), (c == 3) ? 1 : 0);
        end
        check("t4_value", 32'(value_out[0]), 32'hFF80);
        tick();
        dmem_resp = 1'b0;
        settle();
        check("t4_read_down", 32'(dmem_read), 0);

        // stb to even address: lane replication, no regfile write.
        tick();
        q.push_back(mk(op_stb, 0, 5, 16'h00AB, 16'h2000));
        settle();
        tick();
        dmem_resp = 1'b1;
        settle();
        check("t5_write", 32'(dmem_write), 1);
        check("t5_wdata", 32'(dmem_wdata), 32'hABAB);
        check("t5_be", 32'(dmem_byte_enable), 32'b01);
        check("t5_re", 32'(re_count), 1);
        check("t5_ld_busy", 32'(ld_regfile_busy), 0);
        tick();
        dmem_resp = 1'b0;
        settle();
        check("t5_write_down", 32'(dmem_write), 0);

        // Control flow: br without dest pops silently; br with dest stops the group.
        tick();
        q.push_back(mk(op_br, 0, 6, 0, 0));
        q.push_back(mk(op_add, 7, 7, 16'h0777, 0));
        settle();
        check("t6_re", 32'(re_count), 2);
        check("t6_ld_value", 32'(ld_regfile_value), 32'b10);
        tick();
        q.push_back(mk(op_add, 1, 0, 16'h0011, 0));
        q.push_back(mk(op_br, 3, 1, 0, 0));
        settle();
        check("t6_re_stop", 32'(re_count), 1);
        tick();
        q.delete();

        // Reset while waiting on L1, then a stale response.
        q.push_back(mk(op_ldr, 2, 2, 0, 16'h1000));
        settle();
        tick();
        settle();
        check("t7_read_wait", 32'(dmem_read), 1);
        tick();
        rst = 1'b1;
        q.delete();
        settle();
        tick();
        rst = 1'b0;
        dmem_resp = 1'b1;
        settle();
        check("t7_read_after_rst", 32'(dmem_read), 0);
        check("t7_re_after_rst", 32'(re_count), 0);
        check("t7_busy_after_rst", 32'(ld_regfile_busy), 0);
`ifdef COMMIT_PERF_EN
        check("t7_perf_commits", perf_commits, 0);
        check("t7_perf_stall", perf_mem_stall, 0);
`endif

        // Randomized traffic.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            while (q.size() < 4) q.push_back(rand_entry());
            for (int i = 0; i < CW; i++) q[i].rdy = ($urandom % 4) != 0;
            if (pending) q[0].rdy = 1;
            if (!pending && m_branch(q[0].op) && q[0].dest != 0 && ($urandom % 2 == 0))
                q[0].dest = '0;
            dmem_resp  = pending ? (($urandom % 3) == 0) : (($urandom % 8) == 0);
            dmem_rdata = 16'($urandom);
            drive();
            @(negedge clk);
        end

        tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
